mem_bus_ctrl: RTL and testbench

Two-port external memory bus controller for the CPU's multiplexed 20-bit address / 16-bit data pin bus. It arbitrates round-robin between an instruction-fetch port and a data port. It sequences each access as a fixed multiplexed bus cycle: address phase with ALE, a data phase that drives the transceiver enable/direction and write strobe, then recovery. It sits between the core and the I/O pins that feed the external address latches, the chip-select decoder, the bus transceivers and the SRAM.

---
 rtl/mem_bus_ctrl.sv | 168 ++++++++++++++++
 tb/tb_mem_bus_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: two-port round-robin controller for the multiplexed
// 20-bit address / 16-bit data external pin bus.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   req/we/addr/wdata 0,1 fetch (0) and data (1) request ports
//   ack0, ack1            one-cycle completion pulses (RECOV)
//   rdata                 last read data, held until next read
//   busy                  controller not in IDLE
//   ad_out, ad_oe, ad_in  multiplexed pin bus
//   ale, oe, we, pio      latch enable, xcvr OE_n, write strobe/DIR,
//                         chip-select decoder enable
module mem_bus_ctrl #(
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [19:0] addr0,
    input  logic [19:0] addr1,
    input  logic [15:0] wdata0,
    input  logic [15:0] wdata1,
    output logic        ack0,
    output logic        ack1,
    output logic [15:0] rdata,
    output logic        busy,
    output logic [19:0] ad_out,
    output logic        ad_oe,
    input  logic [15:0] ad_in,
    output logic        ale,
    output logic        oe,
    output logic        we,
    output logic        pio
);

    localparam logic [3:0] LP_WS = 4'(WAIT_STATES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_HOLD,
        S_DATA,
        S_RECOV
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_last;
    logic        r_gnt;
    logic        r_we;
    logic [19:0] r_addr;
    logic [15:0] r_wdata;
    logic [15:0] r_rdata;
    logic [3:0]  r_wcnt;

    logic        w_req0;
    logic        w_req1;
    logic        w_any;
    logic        w_pick;
    logic        w_grant;
    logic        w_last_data;
    logic [19:0] w_wr_bus;

    // A port being acked this cycle must not re-win on its stale req.
    assign w_req0 = req0 & ~ack0;
    assign w_req1 = req1 & ~ack1;
    assign w_any  = w_req0 | w_req1;

    // On a tie the port that was not last granted wins.
    assign w_pick = (w_req0 & w_req1) ? ~r_last : w_req1;

    assign w_grant = w_any &
                     ((r_state == S_IDLE) | (r_state == S_RECOV));

    assign w_last_data = (r_state == S_DATA) & (r_wcnt == LP_WS);

    assign w_wr_bus = {r_addr[19:16], r_wdata};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_last  <= 1'b1;
            r_gnt   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_wcnt  <= '0;
        end else begin
            r_state <= w_next;
            if (w_grant) begin
                r_gnt   <= w_pick;
                r_last  <= w_pick;
                r_we    <= w_pick ? we1 : we0;
                r_addr  <= w_pick ? addr1 : addr0;
                r_wdata <= w_pick ? wdata1 : wdata0;
            end
            if (r_state == S_DATA) begin
                r_wcnt <= w_last_data ? 4'd0 : r_wcnt + 4'd1;
            end
            if (w_last_data && !r_we) begin
                r_rdata <= ad_in;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_any) w_next = S_ADDR;
            S_ADDR:  w_next = S_HOLD;
            S_HOLD:  w_next = S_DATA;
            S_DATA:  if (w_last_data) w_next = S_RECOV;
            S_RECOV: w_next = w_any ? S_ADDR : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        ale    = 1'b0;
        oe     = 1'b1;
        we     = 1'b1;
        pio    = 1'b0;
        ad_oe  = 1'b0;
        ad_out = '0;
        ack0   = 1'b0;
        ack1   = 1'b0;
        case (r_state)
            S_ADDR: begin
                ale    = 1'b1;
                pio    = 1'b1;
                ad_oe  = 1'b1;
                ad_out = r_addr;
            end
            S_HOLD: begin
                pio    = 1'b1;
                ad_oe  = 1'b1;
                ad_out = r_addr;
            end
            S_DATA: begin
                oe  = 1'b0;
                pio = 1'b1;
                if (r_we) begin
                    we     = 1'b0;
                    ad_oe  = 1'b1;
                    ad_out = w_wr_bus;
                end
            end
            S_RECOV: begin
                ack0 = ~r_gnt;
                ack1 = r_gnt;
                // Keep write data on the pins past the rising edge of we.
                if (r_we) begin
                    ad_oe  = 1'b1;
                    ad_out = w_wr_bus;
                end
            end
            default: ;
        endcase
    end

    assign rdata = r_rdata;
    assign busy  = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb_mem_bus_ctrl: directed checks of mem_bus_ctrl cycle timing,
// arbitration, reset behaviour and pin strobe ordering.
module tb_mem_bus_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0;
    logic [19:0] addr0 = 0, addr1 = 0;
    logic [15:0] wdata0 = 0, wdata1 = 0, ad_in = 0;
    logic        ack0, ack1, busy, ad_oe, ale, oe, we, pio;
    logic [15:0] rdata;
    logic [19:0] ad_out;

    logic        z_req0 = 0, z_we0 = 0;
    logic [19:0] z_addr0 = 0;
    logic [15:0] z_ad_in = 0;
    logic        z_ack0, z_ack1, z_busy, z_ad_oe, z_ale, z_oe, z_we, z_pio;
    logic [15:0] z_rdata;
    logic [19:0] z_ad_out;

    int n_tot = 0;
    int n_bad = 0;

    mem_bus_ctrl #(.WAIT_STATES(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy),
        .ad_out(ad_out), .ad_oe(ad_oe), .ad_in(ad_in),
        .ale(ale), .oe(oe), .we(we), .pio(pio)
    );

    mem_bus_ctrl #(.WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .req0(z_req0), .req1(1'b0), .we0(z_we0), .we1(1'b0),
        .addr0(z_addr0), .addr1(20'h0),
        .wdata0(16'h0), .wdata1(16'h0),
        .ack0(z_ack0), .ack1(z_ack1), .rdata(z_rdata), .busy(z_busy),
        .ad_out(z_ad_out), .ad_oe(z_ad_oe), .ad_in(z_ad_in),
        .ale(z_ale), .oe(z_oe), .we(z_we), .pio(z_pio)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Strobe ordering / contention rules on both instances.
    always @(negedge clk) begin
        check("inv_main", {29'd0,
              ale & (~oe | ~we),
              ~we & oe,
              ~oe & ad_oe & we}, 32'd0);
        check("inv_ws0", {29'd0,
              z_ale & (~z_oe | ~z_we),
              ~z_we & z_oe,
              ~z_oe & z_ad_oe & z_we}, 32'd0);
    end

    initial begin
        int nack;
        int nale;
        int got;
        int n_oe;

        // reset
        tick();
        check("rst_pins", {ale, oe, we, pio, ad_oe, busy, ack0, ack1},
              8'b0110_0000);
        check("rst_adout", ad_out, 0);
        check("rst_rdata", rdata, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // single read, WAIT_STATES=1
        req0 = 1; we0 = 0; addr0 = 20'h00012; ad_in = 16'hBEEF;
        tick();
        check("rd_c1_ale", ale, 1);
        check("rd_c1_ad", ad_out, 20'h00012);
        check("rd_c1_pio", {ad_oe, pio}, 2'b11);
        addr0 = 20'hFFFFF;
        tick();
        check("rd_c2", {ale, pio, ad_oe}, 3'b011);
        check("rd_c2_ad", ad_out, 20'h00012);
        tick();
        check("rd_c3", {ad_oe, oe, we, ack0}, 4'b0010);
        tick();
        check("rd_c4", {ad_oe, oe, we, ack0}, 4'b0010);
        tick();
        check("rd_c5", {ack0, ack1, oe, pio, ad_oe}, 5'b10100);
        check("rd_c5_data", rdata, 16'hBEEF);
        req0 = 0; ad_in = 16'h0;
        tick();
        check("rd_c6", {ale, pio, busy, ack0}, 4'b0000);
        check("rd_hold", rdata, 16'hBEEF);

        // single write
        req1 = 1; we1 = 1; addr1 = 20'h30040; wdata1 = 16'h1234;
        tick();
        check("wr_c1", {ale, ad_oe}, 2'b11);
        check("wr_c1_ad", ad_out, 20'h30040);
        wdata1 = 16'hFFFF; we1 = 0;
        tick();
        tick();
        check("wr_c3", {we, oe, ad_oe}, 3'b001);
        check("wr_c3_ad", ad_out, 20'h31234);
        tick();
        check("wr_c4", {we, oe, ad_oe}, 3'b001);
        check("wr_c4_ad", ad_out, 20'h31234);
        tick();
        check("wr_c5", {ack1, ack0, we, oe, ad_oe, pio}, 6'b101110);
        check("wr_c5_ad", ad_out, 20'h31234);
        req1 = 0;
        tick();
        check("wr_c6", {ad_oe, busy}, 2'b00);

        // contention: expect 0,1,0,1 every 5 cycles
        req0 = 1; req1 = 1; we0 = 0; we1 = 0;
        addr0 = 20'h00100; addr1 = 20'h00200;
        nack = 0;
        nale = 0;
        for (int c = 1; c <= 40 && nack < 4; c++) begin
            tick();
            check("cont_busy", busy, 1);
            if (ale) begin
                check("cont_addr", ad_out,
                      (nale % 2) ? 20'h00200 : 20'h00100);
                nale++;
            end
            if (ack0 | ack1) begin
                check("cont_port", ack1, nack % 2);
                check("cont_cyc", c, 5 * (nack + 1));
                nack++;
                if (nack == 4) begin
                    req0 = 0;
                    req1 = 0;
                end
            end
        end
        check("cont_n", nack, 4);
        tick();
        check("cont_idle", busy, 0);

        // WAIT_STATES=0 read
        z_req0 = 1; z_we0 = 0; z_addr0 = 20'h0FFFF; z_ad_in = 16'hA5A5;
        n_oe = 0;
        got = 0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c == 1) begin
                check("ws0_ale", z_ale, 1);
                check("ws0_ad", z_ad_out, 20'h0FFFF);
            end
            if (!z_oe) n_oe++;
            if (z_ack0) begin
                check("ws0_cyc", c, 4);
                check("ws0_data", z_rdata, 16'hA5A5);
                z_req0 = 0;
                got++;
            end
        end
        check("ws0_data_len", n_oe, 1);
        check("ws0_nack", got, 1);

        // reset during a write's DATA phase
        req1 = 1; we1 = 1; addr1 = 20'h00100; wdata1 = 16'h5555;
        tick();
        tick();
        tick();
        check("rm_data", {we, oe}, 2'b00);
        #2;
        rst_n = 1'b0;
        #1;
        check("rm_pins", {ale, oe, we, pio, ad_oe, ack1, busy},
              7'b0110000);
        check("rm_ad", ad_out, 0);
        tick();
        rst_n = 1'b1;
        got = 0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (ack1) begin
                check("rm_retry_cyc", c, 5);
                req1 = 0;
                got++;
            end
        end
        check("rm_retry_n", got, 1);

        // random traffic for the strobe checker
        for (int i = 0; i < 300; i++) begin
            tick();
            ad_in = 16'($urandom);
            if (ack0) req0 = 0;
            else if (!req0 && $urandom_range(0, 2) == 0) begin
                req0 = 1;
                we0 = 1'($urandom);
                addr0 = 20'($urandom);
                wdata0 = 16'($urandom);
            end
            if (ack1) req1 = 0;
            else if (!req1 && $urandom_range(0, 2) == 0) begin
                req1 = 1;
                we1 = 1'($urandom);
                addr1 = 20'($urandom);
                wdata1 = 16'($urandom);
            end
        end
        req0 = 0;
        req1 = 0;
        repeat (12) tick();
        check("end_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
